inv_mix_columns_iter: RTL and testbench

- Iterative AES InvMixColumns unit for the decryption datapath; the inverse counterpart of the encryption column mixer.
- Accepts a full 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per cycle.
- Returns the 128-bit result over a valid/ready handshake to the next decryption stage (InvShiftRows/InvSubBytes/AddRoundKey chain).
- The bypass flag passes the state through unchanged, for rounds without InvMixColumns.

---
 rtl/inv_mix_columns_iter.sv | 126 ++++++++++++
 tb/tb_inv_mix_columns_iter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns for the decryption datapath: accepts a 128-bit state,
// mixes COLS_PER_CYCLE columns per cycle in place and returns the result over valid/ready.
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass_flag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_badColsPerCycle
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         r_fsmState;
    state_t         w_nextState;
    logic [127:0]   r_work;
    logic           r_bypass;
    logic [1:0]     r_colCnt;
    logic [127:0]   w_mixed;
    logic           w_lastCol;

    // Bytewise xtime on all four bytes of a column at once.
    function automatic logic [31:0] xtimeWord(input logic [31:0] w);
        logic [31:0] shifted;
        shifted = {w[30:0], 1'b0} & 32'hfefe_fefe;
        return shifted ^ {(w[31] ? 8'h1b : 8'h00),
                          (w[23] ? 8'h1b : 8'h00),
                          (w[15] ? 8'h1b : 8'h00),
                          (w[7]  ? 8'h1b : 8'h00)};
    endfunction

    // Row r needs 0e*b[r], 0b*b[r+1], 0d*b[r+2], 09*b[r+3]; the row offsets become byte rotations.
    function automatic logic [31:0] invMixColumn(input logic [31:0] col);
        logic [31:0] x2;
        logic [31:0] x4;
        logic [31:0] x8;
        logic [31:0] m9;
        logic [31:0] mb;
        logic [31:0] md;
        logic [31:0] me;
        x2 = xtimeWord(col);
        x4 = xtimeWord(x2);
        x8 = xtimeWord(x4);
        m9 = x8 ^ col;
        mb = x8 ^ x2 ^ col;
        md = x8 ^ x4 ^ col;
        me = x8 ^ x4 ^ x2;
        return me ^ {mb[7:0], mb[31:8]} ^ {md[15:0], md[31:16]} ^ {m9[23:0], m9[31:24]};
    endfunction

    always_comb begin
        logic [1:0] w_colIdx;
        w_mixed  = r_work;
        w_colIdx = r_colCnt;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_colIdx = r_colCnt + 2'(j);
            w_mixed[{w_colIdx, 5'd0} +: 32] = r_bypass ? r_work[{w_colIdx, 5'd0} +: 32]
                                                       : invMixColumn(r_work[{w_colIdx, 5'd0} +: 32]);
        end
    end

    assign w_lastCol = ({1'b0, r_colCnt} + 3'(COLS_PER_CYCLE)) == 3'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsmState <= IDLE;
        end else begin
            r_fsmState <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_fsmState;
        unique case (r_fsmState)
            IDLE:    if (in_valid)  w_nextState = BUSY;
            BUSY:    if (w_lastCol) w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_fsmState == IDLE);
        out_valid = (r_fsmState == DONE);
    end

    // The working register doubles as the output register, so out_state never sees inputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work   <= '0;
            r_bypass <= 1'b0;
            r_colCnt <= '0;
        end else begin
            unique case (r_fsmState)
                IDLE: begin
                    if (in_valid) begin
                        r_work   <= in_state;
                        r_bypass <= in_bypass_flag;
                        r_colCnt <= '0;
                    end
                end
                BUSY: begin
                    r_work   <= w_mixed;
                    r_colCnt <= r_colCnt + 2'(COLS_PER_CYCLE);
                end
                default: ;
            endcase
        end
    end

    assign out_state = r_work;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: three instances (1, 2 and 4 columns per cycle) checked
// against a GF(2^8) matrix model, with directed vectors and forward/inverse round trips.
module tb_inv_mix_columns_iter;

    logic         clock = 1'b0;
    logic         reset;
    logic         inValid    [3];
    logic         inReady    [3];
    logic         inBypass   [3];
    logic         outValid   [3];
    logic         outReady   [3];
    logic [127:0] inState    [3];
    logic [127:0] outState   [3];
    logic [127:0] pendingExp [3];
    logic [127:0] expMem     [3][16];
    int           wrPtr      [3];
    int           rdPtr      [3];
    int           accepts    [3];
    int           transfers  [3];
    int           dropped    [3];
    int           latCnt     [3];
    bit           waiting    [3];
    int           total = 0;
    int           bad   = 0;

    localparam logic [127:0] COL_IN   = 128'h00000000_00000000_00000000_bca14d8e;
    localparam logic [127:0] COL_OUT  = 128'h00000000_00000000_00000000_455313db;
    localparam logic [127:0] SEC_IN   = 128'hc6c6c6c6_9d58dc9f_01010101_00000000;
    localparam logic [127:0] SEC_OUT  = 128'hc6c6c6c6_5c220af2_01010101_00000000;
    localparam logic [127:0] BYP_VEC  = 128'h00112233_44556677_8899aabb_ccddeeff;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk            (clock),
            .rst            (reset),
            .in_valid       (inValid[g]),
            .in_ready       (inReady[g]),
            .in_state       (inState[g]),
            .in_bypass_flag (inBypass[g]),
            .out_valid      (outValid[g]),
            .out_ready      (outReady[g]),
            .out_state      (outState[g])
        );
    end

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    // Circulant column matrix with first row {m0, m1, m2, m3} applied to every column.
    function automatic logic [127:0] mixModel(input logic [127:0] s, input logic [7:0] m0,
                                              input logic [7:0] m1, input logic [7:0] m2,
                                              input logic [7:0] m3);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[32*c + 8*r +: 8] = gmul(m0, s[32*c + 8*r +: 8])
                                   ^ gmul(m1, s[32*c + 8*((r + 1) % 4) +: 8])
                                   ^ gmul(m2, s[32*c + 8*((r + 2) % 4) +: 8])
                                   ^ gmul(m3, s[32*c + 8*((r + 3) % 4) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] invModel(input logic [127:0] s);
        return mixModel(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    endfunction

    function automatic logic [127:0] fwdModel(input logic [127:0] s);
        return mixModel(s, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Single compare process: scoreboard of accepted states, output value, latency and in_ready.
    always @(negedge clock) begin
        for (int g = 0; g < 3; g++) begin
            if (reset) begin
                dropped[g] += wrPtr[g] - rdPtr[g];
                rdPtr[g]   = wrPtr[g];
                waiting[g] = 1'b0;
            end else begin
                if (waiting[g]) latCnt[g]++;
                if (waiting[g] || outValid[g])
                    checkOutput($sformatf("in_ready_low_c%0d", 1 << g), 128'(inReady[g]), 128'd0);
                if (outValid[g]) begin
                    checkOutput($sformatf("output_pending_c%0d", 1 << g),
                                128'(wrPtr[g] != rdPtr[g]), 128'd1);
                    if (wrPtr[g] != rdPtr[g])
                        checkOutput($sformatf("out_state_c%0d", 1 << g), outState[g],
                                    expMem[g][rdPtr[g] % 16]);
                    if (waiting[g]) begin
                        checkOutput($sformatf("latency_c%0d", 1 << g), 128'(latCnt[g]),
                                    128'((4 >> g) + 1));
                        waiting[g] = 1'b0;
                    end
                    if (outReady[g]) begin
                        rdPtr[g]++;
                        transfers[g]++;
                    end
                end
                if (inValid[g] && inReady[g]) begin
                    expMem[g][wrPtr[g] % 16] = pendingExp[g];
                    wrPtr[g]++;
                    accepts[g]++;
                    waiting[g] = 1'b1;
                    latCnt[g]  = 0;
                end
            end
        end
    end

    // Present a state, hold it until accepted, then scramble the inputs to prove they were latched.
    task automatic applyStimulus(input int g, input logic [127:0] st, input logic byp, input logic [127:0] exp);
        int n;
        @(posedge clock);
        #1;
        inValid[g]    = 1'b1;
        inState[g]    = st;
        inBypass[g]   = byp;
        pendingExp[g] = exp;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!inReady[g] && n < 50);
        if (!inReady[g]) checkOutput("in_ready_timeout", 128'(inReady[g]), 128'd1);
        @(posedge clock);
        #1;
        inValid[g]  = 1'b0;
        inBypass[g] = ~byp;
        inState[g]  = ~st;
    endtask

    task automatic drainOutput(input int g, input int stall);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!outValid[g] && n < 50);
        if (!outValid[g]) checkOutput("out_valid_timeout", 128'(outValid[g]), 128'd1);
        repeat (stall) @(negedge clock);
        @(posedge clock);
        #1;
        outReady[g] = 1'b1;
        @(posedge clock);
        #1;
        outReady[g] = 1'b0;
    endtask

    task automatic runTxn(input int g, input logic [127:0] st, input logic byp,
                          input logic [127:0] exp, input int stall);
        applyStimulus(g, st, byp, exp);
        drainOutput(g, stall);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] x;
        logic         byp;
        int           nTxn;

        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            inValid[g]    = 1'b0;
            inBypass[g]   = 1'b0;
            outReady[g]   = 1'b0;
            inState[g]    = '0;
            pendingExp[g] = '0;
            wrPtr[g]      = 0;
            rdPtr[g]      = 0;
            accepts[g]    = 0;
            transfers[g]  = 0;
            dropped[g]    = 0;
            latCnt[g]     = 0;
            waiting[g]    = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("reset_in_ready_c%0d", 1 << g), 128'(inReady[g]), 128'd1);
            checkOutput($sformatf("reset_out_valid_c%0d", 1 << g), 128'(outValid[g]), 128'd0);
            checkOutput($sformatf("reset_out_state_c%0d", 1 << g), outState[g], 128'd0);
        end

        $display("[TB] pinning the reference model with literal vectors");
        checkOutput("model_inv_column", invModel(COL_IN), COL_OUT);
        checkOutput("model_inv_second", invModel(SEC_IN), SEC_OUT);
        checkOutput("model_fwd_column", fwdModel(COL_OUT), COL_IN);
        checkOutput("model_round_trip", invModel(fwdModel(BYP_VEC)), BYP_VEC);

        $display("[TB] directed vectors on every column width");
        for (int g = 0; g < 3; g++) begin
            runTxn(g, COL_IN, 1'b0, COL_OUT, 0);
            runTxn(g, SEC_IN, 1'b0, SEC_OUT, 2);
            runTxn(g, BYP_VEC, 1'b1, BYP_VEC, 1);
        end

        $display("[TB] back-pressure with a waiting input");
        applyStimulus(0, SEC_IN, 1'b0, SEC_OUT);
        for (int n = 0; n < 50 && !outValid[0]; n++) @(negedge clock);
        @(posedge clock);
        #1;
        inValid[0]    = 1'b1;
        inState[0]    = COL_IN;
        inBypass[0]   = 1'b0;
        pendingExp[0] = COL_OUT;
        repeat (10) begin
            @(negedge clock);
            checkOutput("bp_out_valid", 128'(outValid[0]), 128'd1);
            checkOutput("bp_in_ready", 128'(inReady[0]), 128'd0);
        end
        @(posedge clock);
        #1;
        outReady[0] = 1'b1;
        @(posedge clock);
        #1;
        outReady[0] = 1'b0;
        @(negedge clock);
        checkOutput("bp_idle_in_ready", 128'(inReady[0]), 128'd1);
        @(posedge clock);
        #1;
        inValid[0] = 1'b0;
        drainOutput(0, 0);

        $display("[TB] reset in the second busy cycle");
        applyStimulus(0, COL_IN, 1'b0, COL_OUT);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midreset_in_ready", 128'(inReady[0]), 128'd1);
        checkOutput("midreset_out_valid", 128'(outValid[0]), 128'd0);
        checkOutput("midreset_out_state", outState[0], 128'd0);
        repeat (8) @(negedge clock);
        runTxn(0, SEC_IN, 1'b0, SEC_OUT, 0);

        $display("[TB] randomised round trips");
        for (int g = 0; g < 3; g++) begin
            nTxn = (g == 0) ? 1000 : 100;
            for (int i = 0; i < nTxn; i++) begin
                x   = {$urandom, $urandom, $urandom, $urandom};
                byp = ($urandom_range(0, 3) == 0);
                runTxn(g, byp ? x : fwdModel(x), byp, x, $urandom_range(0, 3));
            end
        end

        repeat (4) @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("txn_balance_c%0d", 1 << g), 128'(transfers[g] + dropped[g]),
                        128'(accepts[g]));
            checkOutput($sformatf("queue_empty_c%0d", 1 << g), 128'(wrPtr[g] - rdPtr[g]), 128'd0);
        end
        checkOutput("dropped_c1", 128'(dropped[0]), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
